plugin_collector: RTL and testbench
===================================

PLUGIN_COLLECTOR -- requirements
Module: plugin_collector

Interface
REQ-001 The block SHALL be parameterised as follows:
- NUM_PLUGINS, default 3: number of plugin slots; legal range 1..4.
- WARP_WIDTH, default 16: width of each plugin warp component.
- ERROR_WIDTH, default 32: width of each plugin error value.
- TIMEOUT_CYCLES, default 16: maximum number of COLLECT cycles; legal range 1..255.

REQ-002 The block SHALL have the following ports, with clock and reset first:
- clk  in  1: clock; all state changes on the rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- run  in  1: request one collection pass; sampled in IDLE only.
- plugin_start  out  1: start pulse broadcast to all plugins.
- plugin_valid  in  NUM_PLUGINS: bit i is the valid of plugin i.
- plugin_warp_x/y/z  in  NUM_PLUGINS*WARP_WIDTH: packed warp vectors; plugin i occupies bits [i*WARP_WIDTH +: WARP_WIDTH].
- plugin_error  in  NUM_PLUGINS*ERROR_WIDTH: packed error values, same packing rule.
- busy  out  1: high in every state except IDLE.
- done  out  1: one-cycle pulse when results are updated.
- timeout  out  1: last pass ended on timeout.
- valid_mask  out  NUM_PLUGINS: plugins included in the last pass.
- sum_warp_x/y/z  out  WARP_WIDTH+2: accumulated warp components.
- sum_error  out  ERROR_WIDTH: accumulated error.

Function
REQ-003 The FSM SHALL have the states IDLE, START, COLLECT, ACCUM and DONE, and only the transitions below.
REQ-004 IDLE: when run=1 the FSM SHALL go to START and clear sum_*, valid_mask and timeout to 0; run in any other state SHALL be ignored and SHALL NOT be queued.
REQ-005 START SHALL last exactly 1 cycle with plugin_start=1 and then go to COLLECT; plugin_start SHALL be 0 in every other state.
REQ-006 COLLECT counter behaviour:
- The cycle counter SHALL be 0 on entry and SHALL increment once per COLLECT cycle.
- If plugin_valid is all ones, the FSM SHALL latch valid_mask=plugin_valid and go to ACCUM.
- Otherwise, if the counter equals TIMEOUT_CYCLES-1, the FSM SHALL latch valid_mask=plugin_valid, set timeout=1 and go to ACCUM.
- When both conditions hold in the same cycle, the all-valid condition SHALL win and timeout SHALL stay 0.
REQ-007 ACCUM SHALL last exactly NUM_PLUGINS cycles with index i=0..NUM_PLUGINS-1, one plugin per cycle; in cycle i, if valid_mask[i]=1, slice i SHALL be added to the sums, otherwise the sums SHALL hold.
REQ-008 Inputs SHALL be read live during ACCUM; plugins hold their outputs stable from valid onward, so no input capture is required.
REQ-009 Warp arithmetic: each warp slice SHALL be zero-extended to WARP_WIDTH+2 bits and summed modulo 2^(WARP_WIDTH+2).
REQ-010 Error arithmetic: sum_error SHALL be an unsigned saturating sum that clamps to all-ones and never wraps.
REQ-011 DONE SHALL last 1 cycle with done=1 and then go to IDLE.
REQ-012 sum_*, valid_mask and timeout SHALL hold their values from DONE until the next accepted run.
REQ-013 Latency: with all plugins valid in the first COLLECT cycle, done SHALL be high in the cycle after clock edge NUM_PLUGINS+2, counting the edge that samples run as edge 0.
REQ-014 The block SHALL NOT require plugin_valid to deassert between passes; a valid that is already high SHALL satisfy COLLECT immediately.

Reset
REQ-015 When rst_n=0, asynchronously:
- state SHALL be IDLE and the COLLECT counter and ACCUM index SHALL be 0.
- plugin_start, busy, done, timeout, valid_mask, sum_warp_x/y/z and sum_error SHALL all be 0.
REQ-016 A reset asserted in any state SHALL abort the pass with no done pulse and no retained partial sums; after release the block SHALL accept run on the first IDLE edge.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- V1: 3 plugin models with errors 1, 2, 3 and warp_x=0x0001, 0x0002, 0x0003; run pulse -> plugin_start high for 1 cycle; done after edge 5; sum_error=6; sum_warp_x=0x00006; valid_mask=3'b111; timeout=0.
- V2: warp_x=0xFFFF for all 3 plugins -> sum_warp_x=0x2FFFD (18 bits, no truncation).
- V3: errors 0xFFFFFFFF, 1, 0 -> sum_error=0xFFFFFFFF (saturated).
- V4: plugin 2 never asserts valid, TIMEOUT_CYCLES=16 -> exactly 16 COLLECT cycles; timeout=1; valid_mask=3'b011; sums include plugins 0 and 1 only.
- V5: run held high for the entire pass, then a second pass with plugin_valid still high from pass 1 -> the second pass starts only from IDLE; its COLLECT lasts 1 cycle; its results replace pass 1's.
- V6: rst_n pulsed low mid-ACCUM -> all outputs 0 immediately with no done pulse; a new run afterwards completes normally with the V1 values.

Source files
------------

// File: rtl/plugin_collector.sv
// Collects one result from each plugin per pass: broadcasts a start pulse, waits for all
// valids (or a timeout), then accumulates warp vectors and saturating error one slot per cycle.
module plugin_collector #(
  parameter int NUM_PLUGINS    = 3,
  parameter int WARP_WIDTH     = 16,
  parameter int ERROR_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               run,
  output logic                               plugin_start,
  input  logic [NUM_PLUGINS-1:0]             plugin_valid,
  input  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_x,
  input  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_y,
  input  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_z,
  input  logic [NUM_PLUGINS*ERROR_WIDTH-1:0] plugin_error,
  output logic                               busy,
  output logic                               done,
  output logic                               timeout,
  output logic [NUM_PLUGINS-1:0]             valid_mask,
  output logic [WARP_WIDTH+1:0]              sum_warp_x,
  output logic [WARP_WIDTH+1:0]              sum_warp_y,
  output logic [WARP_WIDTH+1:0]              sum_warp_z,
  output logic [ERROR_WIDTH-1:0]             sum_error
);

  localparam int             IW       = 2;
  localparam logic [7:0]     CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_PLUGINS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    COLLECT = 3'd2,
    ACCUM   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                 state;
  logic [7:0]             cnt;
  logic [IW-1:0]          idx;
  logic [WARP_WIDTH-1:0]  sel_x;
  logic [WARP_WIDTH-1:0]  sel_y;
  logic [WARP_WIDTH-1:0]  sel_z;
  logic [ERROR_WIDTH-1:0] sel_e;
  logic                   sel_v;
  logic [ERROR_WIDTH:0]   err_add;

  // Plugin inputs are read live during ACCUM; the slot is picked by the ACCUM index.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_z = '0;
    sel_e = '0;
    sel_v = 1'b0;
    for (int unsigned i = 0; i < NUM_PLUGINS; i++) begin
      if (idx == IW'(i)) begin
        sel_x = plugin_warp_x[i*WARP_WIDTH +: WARP_WIDTH];
        sel_y = plugin_warp_y[i*WARP_WIDTH +: WARP_WIDTH];
        sel_z = plugin_warp_z[i*WARP_WIDTH +: WARP_WIDTH];
        sel_e = plugin_error[i*ERROR_WIDTH +: ERROR_WIDTH];
        sel_v = valid_mask[i];
      end
    end
  end

  assign err_add = {1'b0, sum_error} + {1'b0, sel_e};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      timeout    <= 1'b0;
      valid_mask <= '0;
      sum_warp_x <= '0;
      sum_warp_y <= '0;
      sum_warp_z <= '0;
      sum_error  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state      <= START;
            timeout    <= 1'b0;
            valid_mask <= '0;
            sum_warp_x <= '0;
            sum_warp_y <= '0;
            sum_warp_z <= '0;
            sum_error  <= '0;
          end
        end
        START: begin
          cnt   <= '0;
          state <= COLLECT;
        end
        COLLECT: begin
          cnt <= cnt + 8'd1;
          // All-valid takes priority over a coincident timeout.
          if (&plugin_valid) begin
            valid_mask <= plugin_valid;
            idx        <= '0;
            state      <= ACCUM;
          end else if (cnt == CNT_LAST) begin
            valid_mask <= plugin_valid;
            timeout    <= 1'b1;
            idx        <= '0;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          if (sel_v) begin
            sum_warp_x <= sum_warp_x + {2'b00, sel_x};
            sum_warp_y <= sum_warp_y + {2'b00, sel_y};
            sum_warp_z <= sum_warp_z + {2'b00, sel_z};
            sum_error  <= err_add[ERROR_WIDTH] ? '1 : err_add[ERROR_WIDTH-1:0];
          end
          if (idx == IDX_LAST) state <= DONE;
          else                 idx   <= idx + IW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign plugin_start = (state == START);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_plugin_collector.sv
// Scenario bench for plugin_collector: expected pass results are queued before each pass
// and compared when done pulses.
module tb_plugin_collector;
  localparam int NP = 3;
  localparam int WW = 16;
  localparam int EW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic              plugin_start;
  logic [NP-1:0]     plugin_valid;
  logic [NP*WW-1:0]  plugin_warp_x, plugin_warp_y, plugin_warp_z;
  logic [NP*EW-1:0]  plugin_error;
  logic              busy, done, timeout;
  logic [NP-1:0]     valid_mask;
  logic [WW+1:0]     sum_warp_x, sum_warp_y, sum_warp_z;
  logic [EW-1:0]     sum_error;

  plugin_collector #(
    .NUM_PLUGINS(NP), .WARP_WIDTH(WW), .ERROR_WIDTH(EW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .plugin_start(plugin_start),
    .plugin_valid(plugin_valid), .plugin_warp_x(plugin_warp_x),
    .plugin_warp_y(plugin_warp_y), .plugin_warp_z(plugin_warp_z),
    .plugin_error(plugin_error), .busy(busy), .done(done), .timeout(timeout),
    .valid_mask(valid_mask), .sum_warp_x(sum_warp_x), .sum_warp_y(sum_warp_y),
    .sum_warp_z(sum_warp_z), .sum_error(sum_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW+1:0] x, y, z;
    logic [EW-1:0] e;
    logic [NP-1:0] m;
    logic          t;
    int            edge_n;
  } exp_t;

  exp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;
  logic [WW-1:0] wx[NP], wy[NP], wz[NP];
  logic [EW-1:0] er[NP];

  task automatic load(input logic [WW-1:0] x0, x1, x2, input logic [EW-1:0] e0, e1, e2);
    wx = '{x0, x1, x2};
    er = '{e0, e1, e2};
    for (int i = 0; i < NP; i++) begin
      wy[i] = wx[i] << 1;
      wz[i] = wx[i] ^ 16'hA5A5;
      plugin_warp_x[i*WW +: WW] = wx[i];
      plugin_warp_y[i*WW +: WW] = wy[i];
      plugin_warp_z[i*WW +: WW] = wz[i];
      plugin_error[i*EW +: EW]  = er[i];
    end
  endtask

  // Reference result: zero-extended modular warp sums, clamped error sum; c = COLLECT cycles.
  function automatic exp_t model(input logic [NP-1:0] m, input logic t, input int c);
    exp_t r;
    longint ae = 0;
    r.x = '0; r.y = '0; r.z = '0;
    for (int i = 0; i < NP; i++) begin
      if (m[i]) begin
        r.x = r.x + {2'b00, wx[i]};
        r.y = r.y + {2'b00, wy[i]};
        r.z = r.z + {2'b00, wz[i]};
        ae  = ae + longint'(er[i]);
        if (ae > 64'hFFFF_FFFF) ae = 64'hFFFF_FFFF;
      end
    end
    r.e = ae[EW-1:0];
    r.m = m;
    r.t = t;
    r.edge_n = 1 + c + NP;
    return r;
  endfunction

  // Runs one pass from a negedge; plugins in en raise valid on plugin_start, late_mask at late_k.
  task automatic drive_pass(input logic [NP-1:0] en, input bit hold,
                            input logic [NP-1:0] late_mask, input int late_k);
    int start_cnt = 0;
    int start_k = -1;
    int done_k = -1;
    exp_t ex;
    run = 1'b1;
    for (int k = 0; k < 100 && done_k < 0; k++) begin
      @(negedge clk);
      if (!hold) run = 1'b0;
      if (plugin_start) begin
        start_cnt++;
        if (start_k < 0) start_k = k;
        plugin_valid = plugin_valid | en;
      end
      if (k == late_k) plugin_valid = plugin_valid | late_mask;
      if (done) begin
        done_k = k;
        run = 1'b0;
      end
    end
    run = 1'b0;
    tests_run++;
    if (start_cnt !== 1 || start_k !== 0) begin
      tests_failed++;
      $display("FAIL start_pulse: got %0d pulses first at %0d, expected 1 at 0", start_cnt, start_k);
    end
    if (sb.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL scoreboard: done with empty queue");
      return;
    end
    ex = sb.pop_front();
    tests_run++;
    if (done_k !== ex.edge_n) begin
      tests_failed++;
      $display("FAIL done_edge: got %0d expected %0d", done_k, ex.edge_n);
    end
    tests_run++;
    if ({sum_warp_x, sum_warp_y, sum_warp_z} !== {ex.x, ex.y, ex.z}) begin
      tests_failed++;
      $display("FAIL sum_warp: got %h/%h/%h expected %h/%h/%h",
               sum_warp_x, sum_warp_y, sum_warp_z, ex.x, ex.y, ex.z);
    end
    tests_run++;
    if (sum_error !== ex.e) begin
      tests_failed++;
      $display("FAIL sum_error: got %h expected %h", sum_error, ex.e);
    end
    tests_run++;
    if ({valid_mask, timeout} !== {ex.m, ex.t}) begin
      tests_failed++;
      $display("FAIL mask_timeout: got %b/%b expected %b/%b", valid_mask, timeout, ex.m, ex.t);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || sum_error !== ex.e || sum_warp_x !== ex.x ||
        valid_mask !== ex.m || timeout !== ex.t) begin
      tests_failed++;
      $display("FAIL hold_after_done: got done=%b busy=%b err=%h x=%h expected 0/0/%h/%h",
               done, busy, sum_error, sum_warp_x, ex.e, ex.x);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b0;
    plugin_valid = '0;
    load(16'h0, 16'h0, 16'h0, 32'h0, 32'h0, 32'h0);
    #1;
    tests_run++;
    if ({plugin_start, busy, done, timeout, valid_mask, sum_warp_x, sum_warp_y,
         sum_warp_z, sum_error} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got start=%b busy=%b done=%b err=%h expected all 0",
               plugin_start, busy, done, sum_error);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    load(16'h0001, 16'h0002, 16'h0003, 32'd1, 32'd2, 32'd3);
    plugin_valid = '0;
    sb.push_back(model(3'b111, 1'b0, 1));
    drive_pass(3'b111, 1'b0, '0, -1);
  endtask

  task automatic test_warp_wide();
    load(16'hFFFF, 16'hFFFF, 16'hFFFF, 32'd10, 32'd20, 32'd30);
    plugin_valid = '0;
    sb.push_back(model(3'b111, 1'b0, 1));
    drive_pass(3'b111, 1'b0, '0, -1);
  endtask

  task automatic test_saturate();
    load(16'h1234, 16'h0F0F, 16'h8000, 32'hFFFF_FFFF, 32'd1, 32'd0);
    plugin_valid = '0;
    sb.push_back(model(3'b111, 1'b0, 1));
    drive_pass(3'b111, 1'b0, '0, -1);
  endtask

  task automatic test_timeout();
    load(16'h0011, 16'h0022, 16'h0044, 32'd100, 32'd200, 32'd400);
    plugin_valid = '0;
    sb.push_back(model(3'b011, 1'b1, TO));
    drive_pass(3'b011, 1'b0, '0, -1);
  endtask

  task automatic test_valid_at_last_cycle();
    load(16'h0101, 16'h0202, 16'h0404, 32'd5, 32'd6, 32'd7);
    plugin_valid = '0;
    sb.push_back(model(3'b111, 1'b0, TO));
    drive_pass(3'b011, 1'b0, 3'b100, TO);
  endtask

  task automatic test_back_to_back();
    int busy_seen = 0;
    load(16'h0001, 16'h0002, 16'h0003, 32'd1, 32'd2, 32'd3);
    plugin_valid = '0;
    sb.push_back(model(3'b111, 1'b0, 1));
    drive_pass(3'b111, 1'b1, '0, -1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    tests_run++;
    if (busy_seen !== 0) begin
      tests_failed++;
      $display("FAIL run_not_queued: got %0d busy cycles expected 0", busy_seen);
    end
    load(16'h0400, 16'h0500, 16'h0600, 32'd7, 32'd8, 32'd9);
    sb.push_back(model(3'b111, 1'b0, 1));
    drive_pass(3'b000, 1'b0, '0, -1);
  endtask

  task automatic test_reset_abort();
    int done_seen = 0;
    load(16'h0001, 16'h0002, 16'h0003, 32'd1, 32'd2, 32'd3);
    plugin_valid = '0;
    run = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      run = 1'b0;
      if (plugin_start) plugin_valid = 3'b111;
    end
    tests_run++;
    if (busy !== 1'b1 || sum_error !== 32'd1) begin
      tests_failed++;
      $display("FAIL mid_accum: got busy=%b err=%h expected 1/00000001", busy, sum_error);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({plugin_start, busy, done, timeout, valid_mask, sum_warp_x, sum_warp_y,
         sum_warp_z, sum_error} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got busy=%b done=%b err=%h x=%h expected all 0",
               busy, done, sum_error, sum_warp_x);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    tests_run++;
    if (done_seen !== 0) begin
      tests_failed++;
      $display("FAIL no_done_in_reset: got %0d pulses expected 0", done_seen);
    end
    rst_n = 1'b1;
    plugin_valid = '0;
    sb.push_back(model(3'b111, 1'b0, 1));
    drive_pass(3'b111, 1'b0, '0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_warp_wide();
    test_saturate();
    test_timeout();
    test_valid_at_last_cycle();
    test_back_to_back();
    test_reset_abort();
    tests_run++;
    if (sb.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
